// File: rtl/mips_pkg.sv
// Shared codes for the multicycle MIPS control path.
// Contents: the control FSM state enum, opcode constants, and the encodings
// of the alu_op, alu_src_b, pc_source and ext_op control fields. It also has
// a helper that maps an opcode to its immediate-extension mode.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_REXEC,
        ST_RWB,
        ST_BEQEX,
        ST_IEXEC,
        ST_IWB,
        ST_JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_LOGIC} alu_op_t;
    typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_t;
    typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_RSVD} pc_source_t;
    typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_RSVD} ext_op_t;

    // Logical immediates are zero-extended, lui shifts into the upper half,
    // everything else (addi, lw/sw offsets, beq) is sign-extended.
    function automatic ext_op_t ext_mode(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI: return EXT_ZERO;
            OP_LUI:          return EXT_LUI;
            default:         return EXT_SIGN;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle control unit and the datapath.
// master: control unit (takes opcode/mem_ready, drives every select/strobe).
// slave : datapath side (drives opcode/mem_ready, consumes the controls).
interface mc_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] ext_op;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, ext_op, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, ext_op, illegal
    );
endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state and opcode dispatch for the multicycle control FSM.
// Ports:
//   i_state     current state
//   i_opcode    instruction[31:26], only looked at in DECODE
//   i_mem_ready memory completion, only looked at in FETCH/MEMRD/MEMWR
//   i_is_store  sw flag captured in DECODE, steers MEMADR
//   o_next      next state
//   o_illegal   high in DECODE when the opcode is not decoded
module mc_next_state
    import mips_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    input  logic       i_is_store,
    output state_t     o_next,
    output logic       o_illegal
);

    always_comb begin
        o_next    = i_state;
        o_illegal = 1'b0;
        case (i_state)
            ST_IDLE:   o_next = ST_FETCH;
            ST_FETCH:  o_next = i_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW:                     o_next = ST_MEMADR;
                    OP_RTYPE:                         o_next = ST_REXEC;
                    OP_BEQ:                           o_next = ST_BEQEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: o_next = ST_IEXEC;
                    OP_J:                             o_next = ST_JEX;
                    default: begin
                        o_next    = ST_FETCH;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: o_next = i_is_store ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  o_next = i_mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  o_next = i_mem_ready ? ST_FETCH : ST_MEMWR;
            ST_REXEC:  o_next = ST_RWB;
            ST_IEXEC:  o_next = ST_IWB;
            ST_MEMWB, ST_RWB, ST_BEQEX, ST_IWB, ST_JEX: o_next = ST_FETCH;
            default:   o_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit (Moore FSM) sequencing the shared datapath
// from FETCH through writeback.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   mc_control_if.master: opcode/mem_ready in, all selects,
//         strobes, ext_op and illegal out
// Outputs are decoded straight from the state register (ir_write/pc_write
// in FETCH are additionally gated by mem_ready). ext_op is a register
// loaded in DECODE so the extender mode stays put for the rest of the
// instruction and beyond, until the next DECODE.
module mc_control
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic       w_illegal;
    ext_op_t    r_ext_op;
    logic       r_is_store;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    alu_src_b_t w_alu_src_b;
    alu_op_t    w_alu_op;
    pc_source_t w_pc_source;

    mc_next_state u_next (
        .i_state     (r_state),
        .i_opcode    (bus.opcode),
        .i_mem_ready (bus.mem_ready),
        .i_is_store  (r_is_store),
        .o_next      (w_next),
        .o_illegal   (w_illegal)
    );

    // Opcode-derived state is captured once in DECODE; later states use the
    // captured copies instead of re-reading the instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ext_op   <= EXT_SIGN;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_ext_op   <= ext_mode(bus.opcode);
                r_is_store <= (bus.opcode == OP_SW);
            end
        end
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_RT;
        w_alu_op        = ALU_ADD;
        w_pc_source     = PCSRC_ALU;
        case (r_state)
            ST_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                // IR and PC load only on the completing cycle of the read.
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            ST_DECODE: w_alu_src_b = SRCB_IMM_SH2;
            ST_MEMADR, ST_IEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                // Zero-extend mode is set exactly for andi/ori, which are
                // also the only immediates needing the logic ALU op.
                if (r_state == ST_IEXEC && r_ext_op == EXT_ZERO)
                    w_alu_op = ALU_LOGIC;
            end
            ST_MEMRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
            end
            ST_REXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            ST_BEQEX: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCSRC_ALUOUT;
            end
            ST_IWB:   w_reg_write = 1'b1;
            ST_JEX: begin
                w_pc_write  = 1'b1;
                w_pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.pc_write      = w_pc_write;
    assign bus.pc_write_cond = w_pc_write_cond;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.ir_write      = w_ir_write;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.reg_write     = w_reg_write;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.pc_source     = w_pc_source;
    assign bus.ext_op        = r_ext_op;
    assign bus.illegal       = w_illegal;

endmodule
